mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Initiator-side load/store engine between the pipeline MEM stage and the word-wide DataMemory port. Takes one byte, halfword or word load/store request at a time and checks alignment. Performs read-modify-write for sub-word stores, sign/zero-extends load data, and returns one response per request over a valid/ready handshake.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, memory word width (fixed at 32; other values unsupported)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
req_valid  input  1  pipeline request valid
req_ready  output  1  unit can accept a request
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response valid
resp_ready  input  1  pipeline accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal size, or memory error
mem_write_enabled  output  1  memory write strobe
mem_addr  output  32  word-aligned memory address
mem_w_data  output  32  memory write data
mem_r_data  input  32  memory read data, combinational in the same cycle
mem_err  input  1  memory error, sampled in READ/WRITE

Behaviour:
- Byte lanes are little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1. Handshake occurs when req_valid && req_ready.
  - On handshake, register write, size, unsigned, addr and wdata.
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=00; size 11 is always illegal.
  - Fault -> RESP with err=1, rdata=0; no memory access.
  - Load or sub-word store -> READ.
  - Word store -> WRITE.
- READ:
  - mem_addr={addr[31:2],2'b00}, mem_write_enabled=0.
  - Latch mem_r_data into the word buffer. OR mem_err into the err flag.
  - Load -> RESP, with rdata = selected lane extended per size/unsigned.
  - Store -> WRITE.
- WRITE:
  - mem_write_enabled=1 for exactly one cycle; the memory commits at the next posedge.
  - mem_w_data: word store = wdata. Byte/half store = buffer with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - OR mem_err into the err flag. Next state RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_ready.
  - On resp_ready -> IDLE. No new request is accepted in the same cycle (req_ready=0 outside IDLE).
- Latency from handshake at cycle T (resp_ready tied 1):
  - error: resp_valid at T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
- mem_write_enabled is decoded combinationally from state==WRITE only; it is never asserted in any other state.
- mem_addr = 0 and mem_w_data = 0 in IDLE and RESP.
- Reset (asynchronous, any state):
  - State goes to IDLE; all registers clear.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_write_enabled=0, mem_addr=0, mem_w_data=0.
  - req_ready=1 once reset deasserts.
  - Reset asserted during WRITE before the clock edge: no write commits.
- A response held in RESP with resp_ready=0 stalls indefinitely. Inputs to req_* are ignored until return to IDLE.
- Sign extension: lb bit 7 replicated into 31:8; lh bit 15 replicated into 31:16. lw ignores req_unsigned.

Test Plan:
- Memory word at 0x100 = 0x8899AABB.
  - lb addr 0x101 signed -> resp_rdata=0xFFFFFFAA, resp_valid at T+2, resp_err=0.
  - lbu 0x103 -> 0x00000088.
  - lh 0x102 signed -> 0xFFFF8899.
- sb 0x102, wdata=0x12345677 over 0x8899AABB -> one READ cycle, then a single-cycle write of 0x8877AABB to mem_addr 0x100; resp at T+3.
- sw 0x200, wdata=0xDEADBEEF -> no READ cycle; mem_write_enabled high exactly one cycle, write data 0xDEADBEEF; resp at T+2.
- Fault cases, each -> resp_err=1 at T+1, resp_rdata=0, mem_write_enabled never asserted:
  - lh 0x101
  - sw 0x202
  - req_size=11
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid, resp_rdata and resp_err stable throughout; req_ready=0 throughout; a second req_valid is ignored until the return to IDLE.
- Assert reset (low) during WRITE of sh 0x300 -> memory word unchanged; all outputs 0 immediately; req_ready=1 after reset deasserts.
- mem_err=1 during READ of lw 0x400 -> resp_err=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store engine between the MEM stage and a word-wide data memory: one request at a time,
// 1-3 cycles to response; read-modify-write for sub-word stores; a held response stalls all new requests.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_write_enabled,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                req_fault;
  logic [4:0]          shamt;
  logic [DATA_W-1:0]   rd_shift, load_ext, lane_mask, lane_data, merged;
  logic [ADDR_W-1:0]   word_addr;

  assign req_fault = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign shamt     = {addr_q[1:0], 3'b000};
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign rd_shift  = mem_r_data >> shamt;

  always_comb begin
    load_ext  = mem_r_data;
    lane_mask = '0;
    lane_data = '0;
    case (size_q)
      2'b00: begin
        load_ext  = unsigned_q ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
        lane_mask = 32'h0000_00FF << shamt;
        lane_data = {24'b0, wdata_q[7:0]} << shamt;
      end
      2'b01: begin
        load_ext  = unsigned_q ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
        lane_mask = 32'h0000_FFFF << shamt;
        lane_data = {16'b0, wdata_q[15:0]} << shamt;
      end
      default: ;
    endcase
    // Word stores skip READ, so the buffer is meaningless for them.
    merged = (size_q == 2'b10) ? wdata_q : ((buf_q & ~lane_mask) | lane_data);
  end

  always_comb begin
    state_d           = state_q;
    write_d           = write_q;
    size_d            = size_q;
    unsigned_d        = unsigned_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    buf_d             = buf_q;
    rdata_d           = rdata_q;
    err_d             = err_q;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    resp_rdata        = '0;
    resp_err          = 1'b0;
    mem_write_enabled = 1'b0;
    mem_addr          = '0;
    mem_w_data        = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          err_d      = req_fault;
          rdata_d    = '0;
          if (req_fault)                            state_d = RESP;
          else if (req_write && req_size == 2'b10)  state_d = WRITE;
          else                                      state_d = READ;
        end
      end
      READ: begin
        mem_addr = word_addr;
        buf_d    = mem_r_data;
        err_d    = err_q | mem_err;
        if (write_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = (err_q | mem_err) ? '0 : load_ext;
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_write_enabled = 1'b1;
        mem_addr          = word_addr;
        mem_w_data        = merged;
        err_d             = err_q | mem_err;
        state_d           = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory/reference model, directed cases then random traffic.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write_enabled, mem_err;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  logic        pl_en;
  logic [8:0]  pl_idx;
  logic [31:0] pl_dat;
  int          wr_cnt = 0;
  logic [31:0] last_waddr, last_wdata;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write_enabled(mem_write_enabled), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  assign mem_r_data = mem[mem_addr[10:2]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_dat;
    end else if (mem_write_enabled === 1'b1) begin
      mem[mem_addr[10:2]] <= mem_w_data;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_w_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as bytes, results from size/offset rules with integer arithmetic.
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic merr,
                       output logic e_err, output logic [31:0] e_rd, output int e_lat,
                       output int e_wr, output logic [31:0] e_wa, output logic [31:0] e_wd);
    int nbytes, off, idx, v;
    logic [7:0] b [4];
    logic [31:0] word;
    nbytes = 1 << sz;
    off    = int'(a % 4);
    idx    = int'((a / 4) % 512);
    word   = ref_mem[idx];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    e_rd = 0; e_wr = 0; e_wa = 0; e_wd = 0; e_err = 1'b0;
    if (sz == 2'b11 || (off % nbytes) != 0) begin
      e_err = 1'b1;
      e_lat = 1;
    end else if (!w) begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v | (int'(b[off+i]) << (8*i));
      if (!u && nbytes < 4 && v >= (1 << (8*nbytes - 1))) v = v - (1 << (8*nbytes));
      e_err = merr;
      e_rd  = merr ? 32'h0 : 32'(v);
      e_lat = 2;
    end else begin
      for (int i = 0; i < nbytes; i++) b[off+i] = wd[8*i +: 8];
      ref_mem[idx] = {b[3], b[2], b[1], b[0]};
      e_err = merr;
      e_wr  = 1;
      e_wa  = {a[31:2], 2'b00};
      e_wd  = ref_mem[idx];
      e_lat = (nbytes == 4) ? 2 : 3;
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input logic merr,
                        input int hold, output logic [31:0] obs_rd);
    logic e_err;
    logic [31:0] e_rd, e_wa, e_wd;
    int e_lat, e_wr, w0, lat, idx;
    model(w, sz, u, a, wd, merr, e_err, e_rd, e_lat, e_wr, e_wa, e_wd);
    idx = int'((a / 4) % 512);
    w0  = wr_cnt;
    @(negedge clk);
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd; mem_err = merr; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(e_lat));
    check({tag, " rdata"}, resp_rdata, e_rd);
    check({tag, " err"}, 32'(resp_err), 32'(e_err));
    check({tag, " write count"}, 32'(wr_cnt - w0), 32'(e_wr));
    check({tag, " resp mem_addr"}, mem_addr, 32'h0);
    check({tag, " resp mem_w_data"}, mem_w_data, 32'h0);
    check({tag, " resp we"}, 32'(mem_write_enabled), 32'd0);
    if (e_wr > 0) begin
      check({tag, " write addr"}, last_waddr, e_wa);
      check({tag, " write data"}, last_wdata, e_wd);
    end
    check({tag, " mem word"}, mem[idx], ref_mem[idx]);
    obs_rd = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
      req_addr = 32'h40; req_wdata = $urandom;
      @(negedge clk);
      check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold rdata"}, resp_rdata, obs_rd);
      check({tag, " hold err"}, 32'(resp_err), 32'(e_err));
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0; mem_err = 1'b0;
    check({tag, " back idle valid"}, 32'(resp_valid), 32'd0);
    check({tag, " back idle ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] sh_wd;
    int          w0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0; mem_err = 1'b0;
    pl_en = 1'b1; pl_idx = 9'd0; pl_dat = 32'h0;
    #2 reset = 1'b0;
    #1;
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst mem_we", 32'(mem_write_enabled), 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_w_data", mem_w_data, 32'h0);

    for (int i = 0; i < 512; i++) begin
      pl_idx = 9'(i);
      pl_dat = (i == 64) ? 32'h8899AABB : $urandom;
      ref_mem[i] = pl_dat;
      @(negedge clk);
    end
    pl_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", 32'(req_ready), 32'd1);

    do_req("lb 101", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1'b0, 0, rd);
    check("lb 101 const", rd, 32'hFFFFFFAA);
    do_req("lbu 103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 0, rd);
    check("lbu 103 const", rd, 32'h00000088);
    do_req("lh 102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0, 0, rd);
    check("lh 102 const", rd, 32'hFFFF8899);
    do_req("sb 102", 1'b1, 2'b00, 1'b0, 32'h102, 32'h12345677, 1'b0, 0, rd);
    check("sb 102 mem const", mem[64], 32'h8877AABB);
    do_req("sw 200", 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, 0, rd);
    check("sw 200 mem const", mem[128], 32'hDEADBEEF);
    do_req("lh 101 fault", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b0, 0, rd);
    do_req("sw 202 fault", 1'b1, 2'b10, 1'b0, 32'h202, 32'h5A5A5A5A, 1'b0, 0, rd);
    do_req("size11 fault", 1'b1, 2'b11, 1'b0, 32'h104, 32'hFFFFFFFF, 1'b0, 0, rd);
    do_req("lw 100 hold", 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 1'b0, 5, rd);
    check("lw 100 hold const", rd, 32'h8877AABB);

    // Reset while the sub-word store is in its write cycle must drop the write.
    w0 = wr_cnt;
    sh_wd = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h300; req_wdata = sh_wd;
    @(negedge clk);
    req_valid = 1'b0;
    check("sh 300 read we", 32'(mem_write_enabled), 32'd0);
    @(negedge clk);
    check("sh 300 write we", 32'(mem_write_enabled), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midwrite rst we", 32'(mem_write_enabled), 32'd0);
    check("midwrite rst mem_addr", mem_addr, 32'h0);
    check("midwrite rst mem_w_data", mem_w_data, 32'h0);
    check("midwrite rst resp_valid", 32'(resp_valid), 32'd0);
    check("midwrite rst resp_rdata", resp_rdata, 32'h0);
    check("midwrite rst resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midwrite req_ready", 32'(req_ready), 32'd1);
    check("midwrite no write", 32'(wr_cnt - w0), 32'd0);
    check("midwrite mem word", mem[192], ref_mem[192]);

    do_req("lw 400 memerr", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 0, rd);

    for (int n = 0; n < 150; n++) begin
      logic        w;
      logic [1:0]  sz;
      logic [31:0] a;
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 32'h7FF));
      do_req($sformatf("rand%0d", n), w, sz, 1'($urandom), a, $urandom,
             (!w && $urandom_range(0, 7) == 0), $urandom_range(0, 2), rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
